pc_fetch_unit: RTL and testbench

Instruction-fetch front end of the segmented processor. It owns the program counter, issues word reads to instruction memory over a req/ack handshake, and presents the fetched word plus PC+4 to the IF/ID pipeline register (`instru`, `sum2sum`). It also absorbs stalls from the hazard logic and redirects from branch and jump resolution.

---
 rtl/fetch_pkg.sv | 7 +
 rtl/fetch_redirect_mux.sv | 12 +
 rtl/pc_fetch_unit.sv | 98 +++++++++
 tb/tb_pc_fetch_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch front end.
package fetch_pkg;
   typedef enum logic [1:0] {IDLE, REQ, VALID} fetch_state_e;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] PC_STEP          = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/fetch_redirect_mux.sv
// fetch_redirect_mux: merges branch/jump redirects into one word-aligned target.
module fetch_redirect_mux (
   input  logic        branch_take,
   input  logic [31:0] branch_target,
   input  logic        jump_take,
   input  logic [31:0] jump_target,
   output logic        redir_o,
   output logic [31:0] target_o
);
   assign redir_o  = branch_take | jump_take;
   assign target_o = (branch_take ? branch_target : jump_target) & 32'hFFFF_FFFC;
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the PC and fetches one word per REQ/ack handshake,
// honouring hazard stalls and branch/jump redirects.
module pc_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        branch_take,
   input  logic [31:0] branch_target,
   input  logic        jump_take,
   input  logic [31:0] jump_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instru,
   output logic [31:0] sum2sum,
   output logic        instr_valid
);
   localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

   fetch_state_e state_q;
   logic [31:0]  pc_q, pend_tgt_q, instru_q, sum_q;
   logic         pend_q, valid_q;
   logic         redir;
   logic [31:0]  tgt, pc_inc;

   fetch_redirect_mux u_redirect (
      .branch_take  (branch_take),
      .branch_target(branch_target),
      .jump_take    (jump_take),
      .jump_target  (jump_target),
      .redir_o      (redir),
      .target_o     (tgt)
   );

   assign pc_inc = pc_q + PC_STEP;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC_ALIGNED;
         pend_q     <= 1'b0;
         pend_tgt_q <= '0;
         instru_q   <= NOP_INSTR;
         sum_q      <= '0;
         valid_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_q <= REQ;
               pend_q  <= 1'b0;
               if (redir) pc_q <= tgt;
            end
            REQ: begin
               // The request is never withdrawn; a redirect seen while waiting is parked in pend_tgt_q.
               if (imem_ack) begin
                  pend_q <= 1'b0;
                  if (redir || pend_q) begin
                     pc_q    <= redir ? tgt : pend_tgt_q;
                     state_q <= IDLE;
                  end else begin
                     instru_q <= imem_rdata;
                     sum_q    <= pc_inc;
                     valid_q  <= 1'b1;
                     state_q  <= VALID;
                  end
               end else if (redir) begin
                  pend_q     <= 1'b1;
                  pend_tgt_q <= tgt;
               end
            end
            VALID: begin
               pend_q <= 1'b0;
               if (redir) begin
                  pc_q    <= tgt;
                  valid_q <= 1'b0;
                  state_q <= IDLE;
               end else if (!stall_i) begin
                  pc_q    <= pc_inc;
                  valid_q <= 1'b0;
                  state_q <= REQ;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign imem_req    = state_q == REQ;
   assign imem_addr   = pc_q;
   assign instru      = instru_q;
   assign sum2sum     = sum_q;
   assign instr_valid = valid_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed scenario bench for pc_fetch_unit with a handshake memory model.
module tb_pc_fetch_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall_i = 1'b0;
   logic        branch_take = 1'b0;
   logic [31:0] branch_target = '0;
   logic        jump_take = 1'b0;
   logic [31:0] jump_target = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] instru, sum2sum;
   logic        instr_valid;
   int errors = 0;
   int checks = 0;

   pc_fetch_unit #(.RESET_PC(32'h0000_0040)) dut (
      .clk(clk), .rst(rst), .stall_i(stall_i),
      .branch_take(branch_take), .branch_target(branch_target),
      .jump_take(jump_take), .jump_target(jump_target),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instru(instru), .sum2sum(sum2sum), .instr_valid(instr_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input string name, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (imem_req === 1'b1) ok = 1'b1;
         else tick();
      end
      if (!ok) begin
         errors++;
         checks++;
         $display("FAIL %s: imem_req never rose within 20 cycles", name);
      end
   endtask

   // Waits for a request, checks its address, answers after `waits` cycles, then checks the delivered word.
   task automatic fetch(input string name, input logic [31:0] exp_addr, input int waits);
      bit ok;
      logic [31:0] a;
      wait_req(name, ok);
      if (!ok) return;
      a = imem_addr;
      checks++;
      if (a !== exp_addr) begin
         errors++;
         $display("FAIL %s addr: got %h want %h", name, a, exp_addr);
      end
      for (int i = 0; i < waits; i++) tick();
      imem_ack = 1'b1;
      imem_rdata = mem(exp_addr);
      tick();
      imem_ack = 1'b0;
      imem_rdata = '0;
      checks++;
      if (instr_valid !== 1'b1 || instru !== mem(exp_addr) || sum2sum !== exp_addr + 32'd4) begin
         errors++;
         $display("FAIL %s data: valid=%b instru=%h sum2sum=%h want valid=1 instru=%h sum2sum=%h",
                  name, instr_valid, instru, sum2sum, mem(exp_addr), exp_addr + 32'd4);
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instru !== 32'h0 || sum2sum !== 32'h0) begin
         errors++;
         $display("FAIL reset_values: req=%b valid=%b instru=%h sum=%h want 0 0 0 0",
                  imem_req, instr_valid, instru, sum2sum);
      end
      tick();
      rst = 1'b0;
      checks++;
      if (imem_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: req=%b want 0", imem_req);
      end
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
         errors++;
         $display("FAIL reset_first_req: req=%b addr=%h want 1 00000040", imem_req, imem_addr);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) fetch("seq", 32'h40 + 32'(4 * i), 0);
   endtask

   task automatic test_stall();
      logic [31:0] i0, s0;
      i0 = instru;
      s0 = sum2sum;
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instru !== i0 || sum2sum !== s0) begin
            errors++;
            $display("FAIL stall_hold: req=%b valid=%b instru=%h sum=%h want 0 1 %h %h",
                     imem_req, instr_valid, instru, sum2sum, i0, s0);
         end
      end
      stall_i = 1'b0;
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h4C) begin
         errors++;
         $display("FAIL stall_release: req=%b addr=%h want 1 0000004c", imem_req, imem_addr);
      end
      fetch("stall_next", 32'h4C, 1);
   endtask

   task automatic test_branch_wait();
      bit ok;
      wait_req("brwait", ok);
      if (!ok) return;
      branch_take = 1'b1;
      branch_target = 32'h0000_0203;
      tick();
      branch_take = 1'b0;
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h50) begin
         errors++;
         $display("FAIL brwait_hold: req=%b addr=%h want 1 00000050", imem_req, imem_addr);
      end
      imem_ack = 1'b1;
      imem_rdata = 32'h1234_5678;
      tick();
      imem_ack = 1'b0;
      checks++;
      if (instr_valid !== 1'b0 || imem_req !== 1'b0 || instru === 32'h1234_5678) begin
         errors++;
         $display("FAIL brwait_drop: valid=%b req=%b instru=%h want 0 0 not 12345678",
                  instr_valid, imem_req, instru);
      end
      fetch("brwait_next", 32'h200, 0);
   endtask

   task automatic test_branch_jump_same();
      branch_take = 1'b1;
      branch_target = 32'h300;
      jump_take = 1'b1;
      jump_target = 32'h500;
      tick();
      branch_take = 1'b0;
      jump_take = 1'b0;
      checks++;
      if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
         errors++;
         $display("FAIL both_squash: valid=%b req=%b want 0 0", instr_valid, imem_req);
      end
      fetch("both_next", 32'h300, 0);
   endtask

   task automatic test_wrap();
      jump_take = 1'b1;
      jump_target = 32'hFFFF_FFFC;
      tick();
      jump_take = 1'b0;
      fetch("wrap", 32'hFFFF_FFFC, 0);
      checks++;
      if (sum2sum !== 32'h0) begin
         errors++;
         $display("FAIL wrap_sum: got %h want 00000000", sum2sum);
      end
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         errors++;
         $display("FAIL wrap_next: req=%b addr=%h want 1 00000000", imem_req, imem_addr);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      wait_req("rstmid", ok);
      if (!ok) return;
      rst = 1'b1;
      #1;
      checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instru !== 32'h0 || sum2sum !== 32'h0) begin
         errors++;
         $display("FAIL rstmid_values: req=%b valid=%b instru=%h sum=%h want 0 0 0 0",
                  imem_req, instr_valid, instru, sum2sum);
      end
      tick();
      rst = 1'b0;
      imem_ack = 1'b1;
      imem_rdata = 32'hBAD0_BAD0;
      tick();
      imem_ack = 1'b0;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h40 || instr_valid !== 1'b0 || instru !== 32'h0) begin
         errors++;
         $display("FAIL rstmid_late_ack: req=%b addr=%h valid=%b instru=%h want 1 00000040 0 00000000",
                  imem_req, imem_addr, instr_valid, instru);
      end
      fetch("rstmid_fetch", 32'h40, 0);
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_stall();
      test_branch_wait();
      test_branch_jump_same();
      test_wrap();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
